// File: rtl/res_encoder_pkg.sv
// Shared definitions for the result-return encoder: FSM state encoding,
// frame header layout and the frame checksum rule (also used by the
// command decoder side).
package res_encoder_pkg;

  // Frame FSM states
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    HDR     = 3'd1,
    WAIT_TX = 3'd2,
    RD      = 3'd3,
    RD_WAIT = 3'd4,
    SEND    = 3'd5,
    CHK     = 3'd6
  } state_t;

  // Header byte is {zero pad, size code}
  localparam int NCODE_W   = 3;
  localparam int HDR_PAD_W = 8 - NCODE_W;

  function automatic logic [7:0] hdr_byte(input logic [NCODE_W-1:0] ncode);
    return {{HDR_PAD_W{1'b0}}, ncode};
  endfunction

  // Running checksum: XOR of every byte of the frame before the checksum
  function automatic logic [7:0] chk_update(input logic [7:0] chk, input logic [7:0] b);
    return chk ^ b;
  endfunction

endpackage

// File: rtl/res_encoder_if.sv
// Bundle of the encoder's core, result-memory and UART-TX signals.
// master = the encoder, slave = its environment.
interface res_encoder_if
  import res_encoder_pkg::*;
#(
  parameter int WORD_W = 16,
  parameter int ADDR_W = 7
) ();
  logic               Start_in;
  logic [NCODE_W-1:0] N_code_in;
  logic               Y_Ena_out;
  logic [ADDR_W-1:0]  Y_Addra_out;
  logic [WORD_W-1:0]  Y_Douta_in;
  logic [7:0]         Tx_Byte_out;
  logic               Tx_DV_out;
  logic               Tx_Done_in;
  logic               Busy_out;
  logic               Done_out;

  modport master (
    input  Start_in, N_code_in, Y_Douta_in, Tx_Done_in,
    output Y_Ena_out, Y_Addra_out, Tx_Byte_out, Tx_DV_out, Busy_out, Done_out
  );

  modport slave (
    output Start_in, N_code_in, Y_Douta_in, Tx_Done_in,
    input  Y_Ena_out, Y_Addra_out, Tx_Byte_out, Tx_DV_out, Busy_out, Done_out
  );
endinterface

// File: rtl/res_encoder.sv
// Result-return encoder: on a start strobe, reads N result words and sends
// header, payload bytes (MSB first) and XOR checksum to the UART TX, one
// byte outstanding at a time.
module res_encoder
  import res_encoder_pkg::*;
#(
  parameter int WORD_W = 16,
  parameter int ADDR_W = 7
) (
  input  logic           clk,
  input  logic           RST,
  res_encoder_if.master  bus
);

  localparam int BPW   = WORD_W / 8;
  localparam int CNT_W = (BPW > 1) ? $clog2(BPW) : 1;
  localparam int IDX_W = ADDR_W + 1;   // extra bit so N=128 ends without wrap

  state_t             state_q, state_d;
  logic [NCODE_W-1:0] ncode_q, ncode_d;
  logic [IDX_W-1:0]   idx_q, idx_d;       // next word to read
  logic [CNT_W-1:0]   rem_q, rem_d;       // bytes of current word still to send
  logic [WORD_W-1:0]  shreg_q, shreg_d;
  logic [7:0]         byte_q, byte_d;
  logic [7:0]         chk_q, chk_d;
  logic               chk_sent_q, chk_sent_d;
  logic               done_q, done_d;
  logic [IDX_W-1:0]   n_words;

  assign n_words = IDX_W'(1) << ncode_q;

  // Register all state; outputs return to idle values immediately on reset
  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      state_q    <= IDLE;
      ncode_q    <= '0;
      idx_q      <= '0;
      rem_q      <= '0;
      shreg_q    <= '0;
      byte_q     <= '0;
      chk_q      <= '0;
      chk_sent_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      ncode_q    <= ncode_d;
      idx_q      <= idx_d;
      rem_q      <= rem_d;
      shreg_q    <= shreg_d;
      byte_q     <= byte_d;
      chk_q      <= chk_d;
      chk_sent_q <= chk_sent_d;
      done_q     <= done_d;
    end
  end

  // Next-state logic; the byte to emit is loaded on the edge entering HDR/SEND/CHK
  always_comb begin
    state_d    = state_q;
    ncode_d    = ncode_q;
    idx_d      = idx_q;
    rem_d      = rem_q;
    shreg_d    = shreg_q;
    byte_d     = byte_q;
    chk_d      = chk_q;
    chk_sent_d = chk_sent_q;
    done_d     = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.Start_in) begin
          state_d    = HDR;
          ncode_d    = bus.N_code_in;
          byte_d     = hdr_byte(bus.N_code_in);
          chk_d      = chk_update(8'h00, hdr_byte(bus.N_code_in));
          idx_d      = '0;
          rem_d      = '0;
          chk_sent_d = 1'b0;
        end
      end
      HDR: state_d = WAIT_TX;
      WAIT_TX: begin
        if (bus.Tx_Done_in) begin
          if (chk_sent_q) begin
            state_d = IDLE;
            done_d  = 1'b1;
            idx_d   = '0;
          end else if (rem_q != '0) begin
            state_d = SEND;
            rem_d   = rem_q - CNT_W'(1);
            byte_d  = shreg_q[WORD_W-1 -: 8];
            chk_d   = chk_update(chk_q, shreg_q[WORD_W-1 -: 8]);
          end else if (idx_q < n_words) begin
            state_d = RD;
          end else begin
            state_d    = CHK;
            byte_d     = chk_q;
            chk_sent_d = 1'b1;
          end
        end
      end
      RD: state_d = RD_WAIT;
      RD_WAIT: begin
        state_d = SEND;
        shreg_d = bus.Y_Douta_in;
        byte_d  = bus.Y_Douta_in[WORD_W-1 -: 8];
        chk_d   = chk_update(chk_q, bus.Y_Douta_in[WORD_W-1 -: 8]);
        rem_d   = CNT_W'(BPW - 1);
        idx_d   = idx_q + IDX_W'(1);
      end
      SEND: begin
        state_d = WAIT_TX;
        shreg_d = shreg_q << 8;
      end
      CHK: state_d = WAIT_TX;
      default: state_d = IDLE;
    endcase
  end

  assign bus.Y_Ena_out   = (state_q == RD);
  assign bus.Y_Addra_out = idx_q[ADDR_W-1:0];
  assign bus.Tx_Byte_out = byte_q;
  assign bus.Tx_DV_out   = (state_q == HDR) || (state_q == SEND) || (state_q == CHK);
  assign bus.Busy_out    = (state_q != IDLE);
  assign bus.Done_out    = done_q;

endmodule

// File: doc/res_encoder.md
# res_encoder

Result-return encoder for the matrix-vector engine: the transmit-side counterpart of the UART command decoder. When the compute core signals completion, it reads the N-word result vector Y from the result memory and streams it to the UART transmitter as a framed byte sequence: size header, payload bytes MSB-first, XOR checksum. It sits between the result BRAM, the core's done strobe and the UART TX module, and owns the read port of the result memory.

## Interface

Parameters:
- WORD_W, 16: result word width; must be a multiple of 8.
- ADDR_W, 7: result memory address width; covers N up to 128.

Ports:
- clk, input, 1: single clock; all logic rising-edge.
- RST, input, 1: asynchronous, active-high reset.
- Start_in, input, 1: one-cycle pulse from the core; result vector is complete.
- N_code_in, input, 3: size code; N = 1 << N_code_in (1..128). Sampled on the accepted Start_in.
- Y_Ena_out, output, 1: result memory read enable.
- Y_Addra_out, output, ADDR_W: result memory read address.
- Y_Douta_in, input, WORD_W: result memory read data; 1-cycle read latency.
- Tx_Byte_out, output, 8: byte to UART TX; held stable until the next Tx_DV_out.
- Tx_DV_out, output, 1: one-cycle pulse; Tx_Byte_out is valid.
- Tx_Done_in, input, 1: one-cycle pulse from UART TX; the previous byte is fully sent.
- Busy_out, output, 1: frame in progress.
- Done_out, output, 1: one-cycle pulse; the frame is fully transmitted.

## Operation

- Frame: header byte {5'b0, N_code}, then N words with WORD_W/8 bytes each (MSB byte first, address 0 upward), then checksum byte = XOR of every prior byte including the header. Total bytes = 2 + N·WORD_W/8.
- States and transitions:
  - IDLE -> HDR on Start_in.
  - HDR issues the header, then goes to WAIT_TX.
  - WAIT_TX waits for Tx_Done_in, then:
    - goes to RD if words remain and the current word is exhausted;
    - goes to SEND if bytes of the current word remain;
    - goes to CHK if all words are sent;
    - goes to IDLE if the checksum was just sent.
  - RD asserts Y_Ena_out with Y_Addra_out = word index, then goes to RD_WAIT.
  - RD_WAIT captures Y_Douta_in into the word shift register, then goes to SEND.
  - SEND issues the top byte, shifts the register left 8, then goes to WAIT_TX.
  - CHK issues the checksum, then goes to WAIT_TX.
- Counters:
  - Word index is ADDR_W+1 bits wide so that N=128 terminates without wrap.
  - Byte-in-word counter is log2(WORD_W/8) bits, minimum 1.
- Ignored inputs:
  - Start_in while Busy_out is high: no effect on the frame or on the latched N_code.
  - Tx_Done_in outside WAIT_TX.
- Only one byte is ever outstanding. Tx_DV_out is never reasserted before Tx_Done_in.

## Timing

- Reset values: Y_Ena_out=0, Y_Addra_out=0, Tx_Byte_out=0, Tx_DV_out=0, Busy_out=0, Done_out=0; state IDLE; checksum 0.
- Start_in at cycle 0: Busy_out=1 and Tx_DV_out=1 with the header at cycle 1.
- Tx_Done_in at cycle t, new word needed: Y_Ena_out=1 at t+1, data captured at t+2, Tx_DV_out at t+3.
- Tx_Done_in at cycle t, same word: next Tx_DV_out at t+1.
- Tx_Done_in at cycle t after the last payload byte: checksum Tx_DV_out at t+1.
- Tx_Done_in for the checksum at cycle t: Done_out=1 and Busy_out=0 at t+1; Y_Addra_out returns to 0.
- Start_in in the same cycle as Done_out is accepted; the new header follows at the next cycle.
- RST mid-frame: all outputs go to reset values immediately; no Done_out; the partial frame is abandoned.

## Structure

- Shared package holds:
  - state encoding localparams: IDLE, HDR, WAIT_TX, RD, RD_WAIT, SEND, CHK;
  - the frame header layout;
  - the checksum rule, so it is shared with the command decoder side.
- Optional sub-module res_word_serializer: loads WORD_W bits, emits MSB-first bytes on a shift strobe, and flags the last byte. The FSM and checksum stay in res_encoder.

## Test plan

- N_code=1, WORD_W=16, Y={0x1234,0xABCD}, Tx_Done 10 cycles after each DV -> bytes 01,12,34,AB,CD,41; one Done_out pulse; Busy_out low after.
- N_code=7 -> 258 bytes; addresses 0..127 read exactly once, no wrap; Y_Addra_out=0 at the end.
- Start_in pulsed mid-frame with N_code=2 -> frame continues unchanged; header of the current frame is unaffected; no second frame.
- Tx_Done_in delayed 200 cycles, plus spurious Tx_Done_in pulses in RD/RD_WAIT -> no extra Tx_DV_out; byte order intact.
- RST asserted after the 3rd byte -> outputs at reset values the same cycle; no Done_out; next Start_in yields a complete, correct frame.
- N_code=0, Y[0]=0xFFFF -> bytes 00,FF,FF,00.
